// File: rtl/d_ff_pipe_if.sv
// Bus bundle for d_ff_pipe: input word/valid/enable and the registered pipeline outputs.
// The flush wire exists only when D_FF_PIPE_FLUSH_EN is defined.
interface d_ff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ce;
  logic [WIDTH-1:0] d_in;
  logic             vld_in;
`ifdef D_FF_PIPE_FLUSH_EN
  logic             flush;
`endif
  logic [WIDTH-1:0] d_out;
  logic             vld_out;
  logic [CW-1:0]    fill_cnt;
  logic             primed;

  modport master (
`ifdef D_FF_PIPE_FLUSH_EN
    output flush,
`endif
    output ce, d_in, vld_in,
    input  d_out, vld_out, fill_cnt, primed
  );

  modport slave (
`ifdef D_FF_PIPE_FLUSH_EN
    input  flush,
`endif
    input  ce, d_in, vld_in,
    output d_out, vld_out, fill_cnt, primed
  );
endinterface

// File: rtl/d_ff_pipe.sv
// WIDTH-bit, DEPTH-stage clock-enabled delay line with per-stage valid bits and occupancy count.
// Optional valid-clearing flush port is compiled in with D_FF_PIPE_FLUSH_EN.
module d_ff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic       clock,
  input  logic       rst_syn,
  d_ff_pipe_if.slave pipe
);
  localparam int CW = $clog2(DEPTH + 1);

  // Power-up contents match the reset values.
  logic [WIDTH-1:0] stg_q [DEPTH] = '{default: RST_VAL};
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [DEPTH-1:0] vld_q = {DEPTH{1'b0}};
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    cnt_q = {CW{1'b0}};
  logic [CW-1:0]    cnt_d;
  logic             primed_q = 1'b0;
  logic             primed_d;
  logic [CW:0]      cnt_sum_s;
  logic             flush_s;

`ifdef D_FF_PIPE_FLUSH_EN
  assign flush_s = pipe.flush;
`else
  assign flush_s = 1'b0;
`endif

  // Next-state: flush clears valids only, ce shifts everything, otherwise hold.
  always_comb begin
    stg_d     = stg_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    cnt_sum_s = {1'b0, cnt_q};
    if (flush_s) begin
      vld_d = {DEPTH{1'b0}};
      cnt_d = {CW{1'b0}};
    end else if (pipe.ce) begin
      stg_d[0] = pipe.d_in;
      vld_d[0] = pipe.vld_in;
      for (int k = 1; k < DEPTH; k++) begin
        stg_d[k] = stg_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
      cnt_sum_s = {1'b0, cnt_q} + (CW+1)'(pipe.vld_in) - (CW+1)'(vld_q[DEPTH-1]);
      cnt_d     = cnt_sum_s[CW-1:0];
    end else begin
      cnt_d = cnt_q;
    end
    primed_d = (cnt_d == CW'(DEPTH));
  end

  // State registers with synchronous reset taking priority over flush and enable.
  always_ff @(posedge clock) begin
    if (rst_syn) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k] <= RST_VAL;
      end
      vld_q    <= {DEPTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      primed_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k] <= stg_d[k];
      end
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign pipe.d_out    = stg_q[DEPTH-1];
  assign pipe.vld_out  = vld_q[DEPTH-1];
  assign pipe.fill_cnt = cnt_q;
  assign pipe.primed   = primed_q;
endmodule

// File: doc/d_ff_pipe.md
# d_ff_pipe

Parametrised register pipeline: the multi-bit, multi-stage successor to the single-bit D flip-flop. It delays a WIDTH-bit word by DEPTH clock-enabled cycles. A valid bit travels with each stage, and a live occupancy count is kept. It is used as the standard retiming/delay element for CLB-level datapaths on 7-series targets: alignment of parallel paths and pipelining long routes.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset
- clock  input  1  rising-edge clock, sole clock of the block
- rst_syn  input  1  reset, synchronous and active-high
- ce  input  1  clock enable; pipeline advances only when high
- d_in  input  WIDTH  data into stage 0
- vld_in  input  1  valid flag accompanying d_in
- flush  input  1  clears valid bits; present only with D_FF_PIPE_FLUSH_EN
- d_out  output  WIDTH  data of stage DEPTH-1
- vld_out  output  1  valid flag of stage DEPTH-1
- fill_cnt  output  $clog2(DEPTH+1)  number of stages currently holding valid data
- primed  output  1  high when fill_cnt == DEPTH

## Operation
- Storage per stage: data register stg[k] (WIDTH bits) and vld[k] (1 bit), for k = 0..DEPTH-1.
- Priority at each rising clock edge: rst_syn, then flush (if compiled in), then ce, then hold.
- rst_syn = 1: every stg[k] loads RST_VAL, every vld[k] loads 0, and fill_cnt loads 0. ce and flush are ignored.
- ce = 1 (no reset or flush):
  - stg[0] <= d_in and vld[0] <= vld_in.
  - stg[k] <= stg[k-1] and vld[k] <= vld[k-1] for k >= 1.
  - fill_cnt <= fill_cnt + vld_in - vld[DEPTH-1], computed at full width with no wrap. It is always within 0..DEPTH by construction.
- ce = 0: all state holds. d_in and vld_in are not sampled.
- Data moves regardless of the valid bits. Invalid words still shift; vld marks them as don't-care downstream.
- Outputs are driven directly from registers, with no combinational path from the inputs:
  - d_out = stg[DEPTH-1]
  - vld_out = vld[DEPTH-1]
  - primed = (fill_cnt == DEPTH), registered or derived only from registered state.
- DEPTH = 1: the block behaves as a single WIDTH-bit DFF with enable, synchronous reset and a valid bit. fill_cnt is 1 bit.
- Reset in mid-stream: all in-flight words are discarded. The output returns to RST_VAL/invalid on the cycle after the reset edge.

## Timing
- Latency: a word sampled at clock edge n (with ce = 1) appears on d_out after DEPTH ce-qualified edges.
  - With ce held high, it is visible after edge n+DEPTH-1, i.e. DEPTH cycles after presentation.
  - Cycles with ce = 0 stretch the latency one-for-one.
- Reset values, valid after the first rising edge with rst_syn = 1: d_out = RST_VAL, vld_out = 0, fill_cnt = 0, primed = 0.
- Power-up (before any reset): registers are initialised to the same values via declaration initialisers.
- fill_cnt and primed update on the same edge as the shift that changes occupancy.
- Simultaneous vld_in = 1 and vld_out = 1 with ce = 1: fill_cnt is unchanged.

## Configuration
- Macro: D_FF_PIPE_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush = 1 (and rst_syn = 0): all vld[k] are cleared and fill_cnt is set to 0 on that edge, independent of ce.
  - Data registers hold their contents; they are neither shifted nor reset.
  - d_in and vld_in are not sampled on a flush cycle.
- Undefined: the flush port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: assert rst_syn for 1 cycle with WIDTH=8, DEPTH=4, RST_VAL=8'hA5 -> next cycle d_out=8'hA5, vld_out=0, fill_cnt=0, primed=0.
- Streaming: ce=1, vld_in=1, d_in = 8'h01, 02, 03, ... on consecutive cycles -> 8'h01 appears on d_out with vld_out=1 four cycles after presentation. fill_cnt reads 1,2,3,4; primed=1 from the 4th edge onward.
- Stall: after loading 8'h11, 22 into the pipeline, drop ce for 3 cycles while d_in toggles -> d_out, vld_out and fill_cnt are frozen. When ce resumes, 8'h11 arrives 3 cycles later than the unstalled latency.
- Bubbles: alternate vld_in 1/0 with ce=1 -> vld_out alternates 1/0 after 4 cycles. fill_cnt settles and toggles between 2 and 2 (steady), never exceeding 4.
- Mid-stream reset: a full pipeline (fill_cnt=4) with rst_syn=1 and ce=1 on the same edge -> next cycle fill_cnt=0, d_out=RST_VAL, vld_out=0. No old word emerges afterwards.
- Flush (D_FF_PIPE_FLUSH_EN defined): full pipeline, pulse flush with ce=1 -> fill_cnt=0 and vld_out=0 next cycle, d_out unchanged. A rst_syn+flush pair yields the reset values.
